// File: rtl/sram_sp_ctrl_pkg.sv
// Shared types and default geometry for the single-port SRAM controller.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sram_sp_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DEPTH_DEF  = 64;
  localparam int unsigned DATA_W_DEF = 64;

  // Controller FSM: INIT exists only when the reset-time sweep is compiled in.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Response buffer occupancy, 0..2.
  typedef logic [1:0] resp_cnt_t;

endpackage

// File: rtl/sram_sp_resp_fifo.sv
// Two-entry in-order response buffer sitting behind the SRAM read port.
// Latency: a push is visible at the head one cycle later; head is combinational from state.
// Backpressure: the producer must never push when full without popping; push+pop allowed at any count.
module sram_sp_resp_fifo
  import sram_sp_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic              vld,
  output resp_cnt_t         count,
  output logic [DATA_W-1:0] head_dat
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  resp_cnt_t         cnt_q, cnt_d;

  // Next-state: write at the tail on push, advance the head on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + resp_cnt_t'(push) - resp_cnt_t'(pop);
  end

  // State registers; reset empties the buffer and drops any stored responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign vld      = (cnt_q != '0);
  assign count    = cnt_q;
  assign head_dat = vld ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/sram_sp_ctrl.sv
// Arbitrates write/read request channels onto one SRAM RW port (write priority); optional init sweep under SRAM_RESET_INIT_EN.
// Latency: write issued same cycle as handshake; read data at r_resp_valid two cycles after the read handshake.
// Backpressure: reads stall while a write is requested or while in-flight + buffered responses would exceed 2.
module sram_sp_ctrl
  import sram_sp_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       DEPTH      = DEPTH_DEF,
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [DATA_W-1:0] w_req_data,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("sram_sp_ctrl: DEPTH must equal 2**ADDR_W");
  end

  logic      in_init;
  logic      inflight_q, inflight_d;
  logic      resp_vld, pop, w_hs, r_hs;
  resp_cnt_t buf_cnt;
  logic [2:0] occ_after_pop;

`ifdef SRAM_RESET_INIT_EN
  // One extra counter bit so reaching DEPTH-1 is a plain compare with no wrap.
  localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;

  // Sweep every address once, then settle in IDLE until the next reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == INIT_LAST) begin
        state_d = ST_IDLE;
      end
    end
  end

  // FSM and sweep counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign in_init = (state_q == ST_INIT);
`else
  assign in_init = 1'b0;
`endif

  // Occupancy the buffer would have after this cycle's pop, counting the read already in flight.
  assign pop           = resp_vld && r_resp_ready;
  assign occ_after_pop = 3'(inflight_q) + 3'(buf_cnt) - 3'(pop);

  // Request readies and the SRAM port mux; everything is held at 0 while reset is asserted.
  always_comb begin
    w_req_ready = reset_n && !in_init;
    r_req_ready = reset_n && !in_init && !w_req_valid && (occ_after_pop < 3'd2);
    w_hs        = w_req_valid && w_req_ready;
    r_hs        = r_req_valid && r_req_ready;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
`ifdef SRAM_RESET_INIT_EN
    if (reset_n && in_init) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt_q[ADDR_W-1:0];
      sram_wdata = INIT_VALUE;
    end else
`endif
    if (w_hs) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_req_addr;
      sram_wdata = w_req_data;
    end else if (r_hs) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b0;
      sram_addr  = r_req_addr;
    end
    inflight_d = r_hs;
  end

  // A read issued this cycle has its data on sram_rdata next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  sram_sp_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clk      (clock),
    .rst_n    (reset_n),
    .push     (inflight_q),
    .push_dat (sram_rdata),
    .pop      (pop),
    .vld      (resp_vld),
    .count    (buf_cnt),
    .head_dat (r_resp_data)
  );

  assign r_resp_valid = resp_vld;

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Directed bench for sram_sp_ctrl with a behavioural single-port SRAM model.
// Latency: checks 2-cycle read latency and 1/cycle read throughput.
// Backpressure: checks read stall under a full response buffer and write priority.
module tb_sram_sp_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        w_req_valid, w_req_ready;
  logic [5:0]  w_req_addr;
  logic [63:0] w_req_data;
  logic        r_req_valid, r_req_ready;
  logic [5:0]  r_req_addr;
  logic        r_resp_valid, r_resp_ready;
  logic [63:0] r_resp_data;
  logic        sram_en, sram_wmode;
  logic [5:0]  sram_addr;
  logic [63:0] sram_wdata, sram_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int outstanding = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sram_sp_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .w_req_valid  (w_req_valid),
    .w_req_ready  (w_req_ready),
    .w_req_addr   (w_req_addr),
    .w_req_data   (w_req_data),
    .r_req_valid  (r_req_valid),
    .r_req_ready  (r_req_ready),
    .r_req_addr   (r_req_addr),
    .r_resp_valid (r_resp_valid),
    .r_resp_ready (r_resp_ready),
    .r_resp_data  (r_resp_data),
    .sram_en      (sram_en),
    .sram_wmode   (sram_wmode),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  // Behavioural SRAM: registered read, garbage on the read bus when no read was issued.
  logic [63:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom} | 64'h1;
  always @(posedge clock) begin
    if (sram_en && sram_wmode) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
    else sram_rdata <= {$urandom, $urandom};
  end

  // Accepted-but-unconsumed reads must stay within 0..2: catches overflow and stale responses.
  always @(negedge clock) begin
    if (!reset_n) begin
      outstanding = 0;
    end else begin
      if (r_req_valid && r_req_ready) outstanding++;
      if (r_resp_valid && r_resp_ready) outstanding--;
      checks++;
      if (outstanding > 2 || outstanding < 0) begin
        failures++;
        $display("FAIL resp_occupancy got=%0d allowed=0..2 cyc=%0d", outstanding, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    w_req_valid = 1'b0;
    w_req_addr  = '0;
    w_req_data  = '0;
    r_req_valid = 1'b0;
    r_req_addr  = '0;
  endtask

  task automatic write_word(input logic [5:0] a, input logic [63:0] d);
    bit ok = 0;
    w_req_valid = 1'b1;
    w_req_addr  = a;
    w_req_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (w_req_ready) begin ok = 1; break; end
      step();
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL write_accept addr=%0d got=no_ready want=ready", a); end
    step();
    w_req_valid = 1'b0;
  endtask

  task automatic read_word(input logic [5:0] a, output logic [63:0] d);
    bit ok = 0;
    r_resp_ready = 1'b1;
    r_req_valid  = 1'b1;
    r_req_addr   = a;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (r_req_ready) begin ok = 1; break; end
      step();
    end
    step();
    r_req_valid = 1'b0;
    d = 'x;
    if (ok) begin
      ok = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clock);
        if (r_resp_valid) begin ok = 1; d = r_resp_data; step(); break; end
        step();
      end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL read_timeout addr=%0d got=no_response want=response", a); end
  endtask

  task automatic test_reset();
    w_req_valid = 1'b1; w_req_addr = 6'd9; w_req_data = 64'hFF;
    r_req_valid = 1'b1; r_req_addr = 6'd9; r_resp_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) step();
    @(negedge clock);
    checks++; if ({w_req_ready, r_req_ready} !== 2'b00) begin failures++; $display("FAIL reset_readies got=%b want=00", {w_req_ready, r_req_ready}); end
    checks++; if (r_resp_valid !== 1'b0 || r_resp_data !== 64'h0) begin failures++; $display("FAIL reset_resp got=%b/%h want=0/0", r_resp_valid, r_resp_data); end
    checks++; if ({sram_en, sram_wmode} !== 2'b00) begin failures++; $display("FAIL reset_sram_ctl got=%b want=00", {sram_en, sram_wmode}); end
    checks++; if (sram_addr !== 6'h0 || sram_wdata !== 64'h0) begin failures++; $display("FAIL reset_sram_bus got=%h/%h want=0/0", sram_addr, sram_wdata); end
    idle_inputs();
    step();
    reset_n = 1'b1;
  endtask

`ifdef SRAM_RESET_INIT_EN
  task automatic test_init();
    logic [63:0] d;
    logic [5:0]  addrs [3];
    addrs[0] = 6'd0; addrs[1] = 6'd31; addrs[2] = 6'd63;
    w_req_valid = 1'b1; r_req_valid = 1'b1; r_resp_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      checks++;
      if ({w_req_ready, r_req_ready} !== 2'b00 || {sram_en, sram_wmode} !== 2'b11 ||
          sram_addr !== 6'(i) || sram_wdata !== 64'h0) begin
        failures++;
        $display("FAIL init_sweep cycle=%0d got rdy=%b en/wm=%b addr=%0d wdata=%h want rdy=00 en/wm=11 addr=%0d wdata=0",
                 i, {w_req_ready, r_req_ready}, {sram_en, sram_wmode}, sram_addr, sram_wdata, i);
      end
      step();
    end
    idle_inputs();
    @(negedge clock);
    checks++; if ({w_req_ready, r_req_ready} !== 2'b11) begin failures++; $display("FAIL init_exit_ready got=%b want=11", {w_req_ready, r_req_ready}); end
    step();
    for (int k = 0; k < 3; k++) begin
      read_word(addrs[k], d);
      checks++; if (d !== 64'h0) begin failures++; $display("FAIL init_value addr=%0d got=%h want=0", addrs[k], d); end
    end
  endtask
`else
  task automatic test_no_init();
    @(negedge clock);
    checks++; if ({w_req_ready, r_req_ready} !== 2'b11) begin failures++; $display("FAIL first_cycle_ready got=%b want=11", {w_req_ready, r_req_ready}); end
    checks++; if (sram_en !== 1'b0) begin failures++; $display("FAIL first_cycle_idle_en got=%b want=0", sram_en); end
    step();
  endtask
`endif

  task automatic test_write_read();
    r_resp_ready = 1'b0;
    w_req_valid = 1'b1; w_req_addr = 6'd5; w_req_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clock);
    checks++; if (w_req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b want=1", w_req_ready); end
    checks++; if ({sram_en, sram_wmode} !== 2'b11 || sram_addr !== 6'd5 || sram_wdata !== 64'hDEADBEEF_CAFEF00D) begin
      failures++; $display("FAIL wr_port got en/wm=%b addr=%0d data=%h want 11/5/deadbeefcafef00d", {sram_en, sram_wmode}, sram_addr, sram_wdata);
    end
    step();
    w_req_valid = 1'b0; r_req_valid = 1'b1; r_req_addr = 6'd5;
    @(negedge clock);
    checks++; if (r_req_ready !== 1'b1 || {sram_en, sram_wmode} !== 2'b10 || sram_addr !== 6'd5) begin
      failures++; $display("FAIL rd_port got rdy=%b en/wm=%b addr=%0d want 1/10/5", r_req_ready, {sram_en, sram_wmode}, sram_addr);
    end
    step();
    r_req_valid = 1'b0;
    @(negedge clock);
    checks++; if (r_resp_valid !== 1'b0 || sram_en !== 1'b0) begin failures++; $display("FAIL rd_lat_early got valid=%b en=%b want 0/0", r_resp_valid, sram_en); end
    step();
    @(negedge clock);
    checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== 64'hDEADBEEF_CAFEF00D) begin
      failures++; $display("FAIL rd_lat_data got valid=%b data=%h want 1/deadbeefcafef00d", r_resp_valid, r_resp_data);
    end
    r_resp_ready = 1'b1;
    step();
    @(negedge clock);
    checks++; if (r_resp_valid !== 1'b0) begin failures++; $display("FAIL rd_pop got valid=%b want=0", r_resp_valid); end
    step();
  endtask

  task automatic test_conflict();
    r_resp_ready = 1'b1;
    w_req_valid = 1'b1; w_req_addr = 6'd7; w_req_data = 64'h1234;
    r_req_valid = 1'b1; r_req_addr = 6'd7;
    @(negedge clock);
    checks++; if ({w_req_ready, r_req_ready} !== 2'b10 || sram_wmode !== 1'b1) begin
      failures++; $display("FAIL conflict_prio got rdy=%b wmode=%b want 10/1", {w_req_ready, r_req_ready}, sram_wmode);
    end
    step();
    w_req_valid = 1'b0;
    @(negedge clock);
    checks++; if (r_req_ready !== 1'b1) begin failures++; $display("FAIL conflict_read_next got=%b want=1", r_req_ready); end
    step();
    r_req_valid = 1'b0;
    step();
    @(negedge clock);
    checks++; if (r_resp_valid !== 1'b1 || r_resp_data !== 64'h1234) begin
      failures++; $display("FAIL conflict_data got valid=%b data=%h want 1/1234", r_resp_valid, r_resp_data);
    end
    step();
  endtask

  task automatic test_back_pressure();
    int na = 0, ng = 0;
    bit hs;
    for (int i = 0; i < 4; i++) write_word(6'(i), 64'h10 + 64'(i));
    r_resp_ready = 1'b0;
    for (int c = 0; c < 36; c++) begin
      if (c == 6) begin
        checks++; if (na != 2) begin failures++; $display("FAIL bp_accepted got=%0d want=2", na); end
        checks++; if (r_req_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b want=0", r_req_ready); end
        r_resp_ready = 1'b1;
      end
      r_req_valid = (na < 4);
      r_req_addr  = 6'(na);
      @(negedge clock);
      hs = r_req_valid && r_req_ready;
      if (r_resp_valid && r_resp_ready) begin
        checks++;
        if (r_resp_data !== 64'h10 + 64'(ng)) begin failures++; $display("FAIL bp_order idx=%0d got=%h want=%h", ng, r_resp_data, 64'h10 + 64'(ng)); end
        ng++;
      end
      step();
      if (hs) na++;
    end
    r_req_valid = 1'b0;
    checks++; if (ng != 4) begin failures++; $display("FAIL bp_count got=%0d want=4", ng); end
  endtask

  task automatic test_back_to_back();
    int na = 0, ng = 0;
    int first_hs = -1, last_hs = -1, first_rsp = -1, last_rsp = -1;
    bit hs;
    for (int i = 0; i < 16; i++) write_word(6'(i), 64'h100 + 64'(i));
    r_resp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      r_req_valid = (na < 16);
      r_req_addr  = 6'(na);
      @(negedge clock);
      hs = r_req_valid && r_req_ready;
      if (hs) begin if (na == 0) first_hs = cyc; last_hs = cyc; end
      if (r_resp_valid) begin
        if (ng == 0) first_rsp = cyc;
        last_rsp = cyc;
        checks++;
        if (r_resp_data !== 64'h100 + 64'(ng)) begin failures++; $display("FAIL b2b_data idx=%0d got=%h want=%h", ng, r_resp_data, 64'h100 + 64'(ng)); end
        ng++;
      end
      step();
      if (hs) na++;
    end
    r_req_valid = 1'b0;
    checks++; if (ng != 16) begin failures++; $display("FAIL b2b_count got=%0d want=16", ng); end
    checks++; if (last_hs - first_hs != 15) begin failures++; $display("FAIL b2b_issue_span got=%0d want=15", last_hs - first_hs); end
    checks++; if (first_rsp - first_hs != 2) begin failures++; $display("FAIL b2b_latency got=%0d want=2", first_rsp - first_hs); end
    checks++; if (last_rsp - first_rsp != 15) begin failures++; $display("FAIL b2b_resp_span got=%0d want=15", last_rsp - first_rsp); end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] d;
    r_resp_ready = 1'b0;
    r_req_valid = 1'b1; r_req_addr = 6'd0;
    @(negedge clock);
    checks++; if (r_req_ready !== 1'b1) begin failures++; $display("FAIL mid_rd0_ready got=%b want=1", r_req_ready); end
    step();
    r_req_addr = 6'd1;
    @(negedge clock);
    checks++; if (r_req_ready !== 1'b1) begin failures++; $display("FAIL mid_rd1_ready got=%b want=1", r_req_ready); end
    step();
    r_req_valid = 1'b0;
    #1;
    checks++; if (r_resp_valid !== 1'b1) begin failures++; $display("FAIL mid_buffered got=%b want=1", r_resp_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (r_resp_valid !== 1'b0 || sram_en !== 1'b0) begin failures++; $display("FAIL mid_reset_async got valid=%b en=%b want 0/0", r_resp_valid, sram_en); end
    step();
    step();
    reset_n = 1'b1;
    r_resp_ready = 1'b1;
`ifdef SRAM_RESET_INIT_EN
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      checks++;
      if (r_resp_valid !== 1'b0 || w_req_ready !== 1'b0) begin
        failures++; $display("FAIL mid_rerun_init cycle=%0d got valid=%b wrdy=%b want 0/0", i, r_resp_valid, w_req_ready);
      end
      step();
    end
    @(negedge clock);
    checks++; if (w_req_ready !== 1'b1) begin failures++; $display("FAIL mid_init_exit got=%b want=1", w_req_ready); end
    step();
    read_word(6'd0, d);
    checks++; if (d !== 64'h0) begin failures++; $display("FAIL mid_post_read got=%h want=0", d); end
`else
    @(negedge clock);
    checks++; if (w_req_ready !== 1'b1) begin failures++; $display("FAIL mid_idle_immediate got=%b want=1", w_req_ready); end
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++; if (r_resp_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_resp cycle=%0d got=%b want=0", i, r_resp_valid); end
      step();
    end
    read_word(6'd0, d);
    checks++; if (d !== 64'h100) begin failures++; $display("FAIL mid_post_read got=%h want=100", d); end
`endif
  endtask

  initial begin
    idle_inputs();
    r_resp_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    test_reset();
`ifdef SRAM_RESET_INIT_EN
    test_init();
`else
    test_no_init();
`endif
    test_write_read();
    test_conflict();
    test_back_pressure();
    test_back_to_back();
    test_reset_midstream();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
